shiftout_arbiter: RTL

//  Shares one 16-bit shiftout serialiser between N_REQ requesters. Picks a requester

---
 rtl/shiftout_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/shiftout_arbiter.sv
// -----------------------------------------------------------------------------
// shiftout_arbiter
//   Shares one WIDTH-bit shiftout serialiser between N_REQ requesters. The
//   arbiter picks a requester round-robin and latches its word. It then drives
//   a clean low-then-high edge on the serialiser's data-ready input and waits
//   for the serialiser's latch pulse (lclk), which marks that the word has gone
//   out. When the pulse arrives it acks the owner. A watchdog abandons the
//   transfer if lclk never arrives.
//
// Ports
//   clk_i      in   system clock, rising edge
//   reset_ni   in   asynchronous active-low reset
//   req_i      in   [N_REQ]        level request per requester
//   data_i     in   [N_REQ*WIDTH]  requester k word at [k*WIDTH +: WIDTH]
//   grant_o    out  [N_REQ]        one-hot current owner, 0 when idle
//   ack_o      out  [N_REQ]        one-cycle pulse to owner on completion
//   sh_data_o  out  [WIDTH]        word presented to the serialiser
//   sh_rdy_o   out                 serialiser data-ready (rise starts a shift)
//   sh_lclk_i  in                  serialiser latch clock fed back
//   busy_o     out                 high whenever not idle
//   timeout_o  out                 sticky watchdog-abort flag
// -----------------------------------------------------------------------------
module shiftout_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 80
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [N_REQ-1:0]       ack_o,
  output logic [WIDTH-1:0]       sh_data_o,
  output logic                   sh_rdy_o,
  input  logic                   sh_lclk_i,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DONE
  } state_e;

  state_e             state_q,    state_d;
  logic [PW-1:0]      ptr_q,      ptr_d;
  logic [N_REQ-1:0]   grant_q,    grant_d;
  logic [N_REQ-1:0]   ack_q,      ack_d;
  logic [WIDTH-1:0]   data_q,     data_d;
  logic               rdy_q,      rdy_d;
  logic               timeout_q,  timeout_d;
  logic [7:0]         wd_q,       wd_d;
  logic               lclk_old_q, lclk_old_d;

  logic               done;
  logic               win_found;
  logic [PW-1:0]      win_idx;

  // Only a fresh rising edge of lclk counts as completion.
  assign done = sh_lclk_i & ~lclk_old_q;

  // Round-robin search: first set request strictly after the last owner,
  // wrapping modulo N_REQ, so the last owner is considered last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int cand;
      cand = int'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers latches.
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    ack_d      = '0;
    data_d     = data_q;
    rdy_d      = rdy_q;
    timeout_d  = timeout_q;
    wd_d       = wd_q;
    lclk_old_d = sh_lclk_i;

    case (state_q)
      S_IDLE: begin
        rdy_d = 1'b0;
        if (win_found) begin
          data_d           = data_i[int'(win_idx)*WIDTH +: WIDTH];
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          ptr_d            = win_idx;
          state_d          = S_LOAD;
        end
      end
      // Ready stays low for this cycle so the serialiser sees a clean rise.
      S_LOAD:  state_d = S_START;
      S_START: begin
        rdy_d   = 1'b1;
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + 8'd1;
        // A done in the same cycle as watchdog expiry counts as a success.
        if (done) begin
          ack_d[ptr_q] = 1'b1;
          state_d      = S_DONE;
        end else if (wd_q == 8'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        rdy_d   = 1'b0;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      ptr_q      <= PW'(N_REQ - 1);
      grant_q    <= '0;
      ack_q      <= '0;
      data_q     <= '0;
      rdy_q      <= 1'b0;
      timeout_q  <= 1'b0;
      wd_q       <= '0;
      lclk_old_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      rdy_q      <= rdy_d;
      timeout_q  <= timeout_d;
      wd_q       <= wd_d;
      lclk_old_q <= lclk_old_d;
    end
  end

  assign grant_o   = grant_q;
  assign ack_o     = ack_q;
  assign sh_data_o = data_q;
  assign sh_rdy_o  = rdy_q;
  assign timeout_o = timeout_q;
  assign busy_o    = (state_q != S_IDLE);

endmodule
